// File: rtl/gates100_stream_checker_if.sv
// Stream interface for the reduction-flag checker: a narrow data beat
// channel, an expected-flags channel and a result channel, each with its
// own valid/ready pair. The checker sits on the slave side.
interface gates100_stream_checker_if #(
    parameter int BEAT = 10
);
    // Data beat channel
    logic            in_valid;
    logic            in_ready;
    logic [BEAT-1:0] in_data;

    // Expected reduction flags from the sender
    logic            exp_valid;
    logic            exp_ready;
    logic            exp_and;
    logic            exp_or;
    logic            exp_xor;

    // Result channel
    logic            res_valid;
    logic            res_ready;
    logic            out_and;
    logic            out_or;
    logic            out_xor;
    logic [2:0]      mismatch;
    logic [7:0]      err_count;

    // Producer / consumer side
    modport master (
        output in_valid, in_data,
        output exp_valid, exp_and, exp_or, exp_xor,
        output res_ready,
        input  in_ready, exp_ready,
        input  res_valid, out_and, out_or, out_xor, mismatch, err_count
    );

    // Checker side
    modport slave (
        input  in_valid, in_data,
        input  exp_valid, exp_and, exp_or, exp_xor,
        input  res_ready,
        output in_ready, exp_ready,
        output res_valid, out_and, out_or, out_xor, mismatch, err_count
    );
endinterface

// File: rtl/gates100_stream_checker.sv
// Sink-side reduction checker. Collects a WIDTH-bit word as NBEATS beats,
// folds each beat into running AND/OR/XOR reductions, then compares them
// with the sender's flags and reports the result with a saturating count
// of words that disagreed.
module gates100_stream_checker #(
    parameter int WIDTH = 100,
    parameter int BEAT  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    gates100_stream_checker_if.slave    bus
);
    localparam int NBEATS = WIDTH / BEAT;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [7:0]       ERR_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_EXP = 2'd1,
        REPORT   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic             acc_and_reg;
    logic             acc_or_reg;
    logic             acc_xor_reg;

    logic             in_ready_reg;
    logic             exp_ready_reg;
    logic             res_valid_reg;
    logic             out_and_reg;
    logic             out_or_reg;
    logic             out_xor_reg;
    logic [2:0]       mismatch_reg;
    logic [7:0]       err_count_reg;

    // Reductions of the beat currently on the bus; the accumulators start
    // at the identity of each operator, so the first beat needs no special
    // handling.
    logic beat_and;
    logic beat_or;
    logic beat_xor;

    assign beat_and = &bus.in_data;
    assign beat_or  = |bus.in_data;
    assign beat_xor = ^bus.in_data;

    // Flag comparison for the word just collected, {and, or, xor}.
    logic [2:0] new_mismatch;

    assign new_mismatch = {acc_and_reg ^ bus.exp_and,
                           acc_or_reg  ^ bus.exp_or,
                           acc_xor_reg ^ bus.exp_xor};

    logic in_fire;
    logic exp_fire;
    logic res_fire;

    assign in_fire  = bus.in_valid  && in_ready_reg;
    assign exp_fire = bus.exp_valid && exp_ready_reg;
    assign res_fire = bus.res_ready && res_valid_reg;

    // Collect / compare / report sequencer. Handshake outputs are registered
    // together with the state so they never depend on inputs in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= COLLECT;
            beat_cnt_reg  <= '0;
            acc_and_reg   <= 1'b1;
            acc_or_reg    <= 1'b0;
            acc_xor_reg   <= 1'b0;
            in_ready_reg  <= 1'b1;
            exp_ready_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            out_and_reg   <= 1'b0;
            out_or_reg    <= 1'b0;
            out_xor_reg   <= 1'b0;
            mismatch_reg  <= 3'b000;
            err_count_reg <= 8'd0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    // Stray expected-flag beats are left on the bus untouched.
                    if (in_fire) begin
                        acc_and_reg <= acc_and_reg & beat_and;
                        acc_or_reg  <= acc_or_reg  | beat_or;
                        acc_xor_reg <= acc_xor_reg ^ beat_xor;
                        if (beat_cnt_reg == LAST_BEAT) begin
                            beat_cnt_reg  <= '0;
                            state_reg     <= WAIT_EXP;
                            in_ready_reg  <= 1'b0;
                            exp_ready_reg <= 1'b1;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end

                WAIT_EXP: begin
                    if (exp_fire) begin
                        out_and_reg  <= acc_and_reg;
                        out_or_reg   <= acc_or_reg;
                        out_xor_reg  <= acc_xor_reg;
                        mismatch_reg <= new_mismatch;
                        if ((new_mismatch != 3'b000) && (err_count_reg != ERR_MAX)) begin
                            err_count_reg <= err_count_reg + 8'd1;
                        end
                        state_reg     <= REPORT;
                        exp_ready_reg <= 1'b0;
                        res_valid_reg <= 1'b1;
                    end
                end

                REPORT: begin
                    // Result and flags stay frozen until the consumer takes them.
                    if (res_fire) begin
                        acc_and_reg   <= 1'b1;
                        acc_or_reg    <= 1'b0;
                        acc_xor_reg   <= 1'b0;
                        state_reg     <= COLLECT;
                        res_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= COLLECT;
                    beat_cnt_reg  <= '0;
                    acc_and_reg   <= 1'b1;
                    acc_or_reg    <= 1'b0;
                    acc_xor_reg   <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    exp_ready_reg <= 1'b0;
                    res_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.exp_ready = exp_ready_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.out_and   = out_and_reg;
    assign bus.out_or    = out_or_reg;
    assign bus.out_xor   = out_xor_reg;
    assign bus.mismatch  = mismatch_reg;
    assign bus.err_count = err_count_reg;

endmodule

// File: doc/gates100_stream_checker.md
Name: gates100_stream_checker

Overview:
- Receive-side counterpart of the 100-bit AND/OR/XOR reduction gate.
- Accepts a WIDTH-bit word serially as BEAT-bit beats over a valid/ready handshake, and accumulates the AND, OR and XOR reductions across beats.
- Then accepts the sender's expected reduction flags and reports the computed flags, a per-flag mismatch vector and a running error count.
- Sits at the sink end of a narrow link that carries wide vectors plus their reduction flags.

Parameters:
- WIDTH, 100, total word width in bits; must be a multiple of BEAT.
- BEAT, 10, bits per input beat; NBEATS = WIDTH/BEAT (10 at defaults).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  data beat valid.
- in_ready  output  1  checker can accept a data beat.
- in_data  input  BEAT  data beat; beat 0 carries word bits [BEAT-1:0], beat k carries bits [k*BEAT+BEAT-1:k*BEAT].
- exp_valid  input  1  expected-flags beat valid.
- exp_ready  output  1  checker can accept expected flags.
- exp_and, exp_or, exp_xor  input  1 each  sender's reduction flags for the word.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- out_and, out_or, out_xor  output  1 each  computed reductions of the full word.
- mismatch  output  3  {and,or,xor} per-flag mismatch, computed XOR expected.
- err_count  output  8  words with any mismatch; saturates at 255.

Behaviour:
- Reset state: state=COLLECT, beat_cnt=0, acc_and=1, acc_or=0, acc_xor=0.
- Reset values: in_ready=1, exp_ready=0, res_valid=0, out_*=0, mismatch=0, err_count=0.
- Reset asserted mid-word or mid-report discards the partial word and any pending result; err_count clears.
- FSM states: COLLECT, WAIT_EXP, REPORT.
- COLLECT: in_ready=1, exp_ready=0, res_valid=0.
  - A beat transfers on in_valid&&in_ready.
  - Per transfer: acc_and <= acc_and & (&in_data); acc_or <= acc_or | (|in_data); acc_xor <= acc_xor ^ (^in_data); beat_cnt increments.
  - On the transfer with beat_cnt==NBEATS-1: beat_cnt <= 0, go to WAIT_EXP.
  - exp_valid in this state is ignored and not consumed.
- WAIT_EXP: in_ready=0, exp_ready=1.
  - On exp_valid: register out_* <= acc_*, mismatch <= {acc_and^exp_and, acc_or^exp_or, acc_xor^exp_xor}.
  - Same edge: if the new mismatch is nonzero and err_count<255, increment err_count; then go to REPORT.
- REPORT: res_valid=1; in_ready=0; exp_ready=0; out_* and mismatch held stable.
  - On res_ready: accumulators return to 1/0/0, go to COLLECT.
  - in_valid is ignored until then; res_ready while res_valid=0 has no effect.
- Outputs out_* and mismatch hold their last values after REPORT until overwritten; they are meaningful only while res_valid=1.
- Latency, best case: last data beat accepted at edge t; exp accepted at t+1; res_valid high from after t+1.
  - Minimum word period is NBEATS+2 cycles with res_ready tied high.
- in_ready, exp_ready and res_valid are decoded from state only, with no combinational input-to-output path.
- Accumulator identity values make the first beat self-initialising; no separate first-beat logic.

Test Plan:
- All ones: ten beats of 0x3FF, exp {1,1,0}, res_ready=1 -> res_valid one cycle after exp; out {and,or,xor}={1,1,0}, mismatch=000, err_count=0.
- All zeros: ten beats 0x000, exp {0,0,0} -> out {0,0,0}, mismatch=000. Repeat back-to-back with in_valid always high -> in_ready low exactly 2 cycles between words.
- Single bit 57 set (beat 5 = 0x080, others 0), exp {0,1,0} -> out {0,1,1}, mismatch=001, err_count=1.
- Backpressure: hold res_ready=0 for 5 cycles during REPORT with in_valid=1 and exp_valid=1 -> res_valid, out_*, mismatch stable; in_ready=0, exp_ready=0; no beats consumed; err_count unchanged. Release -> COLLECT next cycle.
- Reset mid-word: 4 beats of 0x155, assert rst asynchronously between edges -> in_ready=1, res_valid=0, err_count=0 immediately. Then ten beats 0x3FF, exp {1,1,0} -> mismatch=000.
- Stray and saturating cases: exp_valid pulses during COLLECT are not consumed (exp_ready=0). 256 mismatching words -> err_count stops at 255.
